dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port data memory, shared between the CPU load/store path and the UART programmer's data-segment writes (programmer writes with address bit 14 set). CPU accesses have priority. UART writes pass through a one-entry buffer and receive a guaranteed slot through a starvation counter. The block sits between the CPU's memory/IO mux, the UART programmer outputs and the data memory.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory port arbiter between CPU load/store and UART programmer writes
// Statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              upg_wen,
    input  logic [ADDR_W-1:0] upg_addr,
    input  logic [DATA_W-1:0] upg_wdata,
    input  logic              upg_done,
    output logic              upg_busy,
    output logic              upg_overflow,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stat_cpu,
    output logic [15:0]       stat_upg,
    output logic [15:0]       stat_stall
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t            state;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic [CNT_W-1:0]  starve_cnt;

    logic forced;
    logic cpu_issue;
    logic buf_issue;
    logic upg_accept;
    logic upg_drop;

    assign forced = buf_valid && (starve_cnt == LIMIT);

    // Port ownership for this cycle; everything is forced quiet while reset_n is low.
    always_comb begin
        cpu_issue  = 1'b0;
        buf_issue  = 1'b0;
        cpu_stall  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset_n) begin
            if (state == RD_WAIT) begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
                cpu_stall  = cpu_req;
                buf_issue  = buf_valid;
            end else if (forced) begin
                buf_issue = 1'b1;
                cpu_stall = cpu_req;
            end else if (cpu_req) begin
                cpu_issue = 1'b1;
            end else begin
                buf_issue = buf_valid;
            end

            if (buf_issue) begin
                mem_we    = 1'b1;
                mem_addr  = buf_addr;
                mem_wdata = buf_wdata;
            end else if (cpu_issue) begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
        end
    end

    // A full buffer that drains this cycle can take the incoming word.
    assign upg_accept = upg_wen && !upg_done && (!buf_valid || buf_issue);
    assign upg_drop   = upg_wen && !upg_done && buf_valid && !buf_issue;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            buf_valid    <= 1'b0;
            buf_addr     <= '0;
            buf_wdata    <= '0;
            starve_cnt   <= '0;
            upg_overflow <= 1'b0;
        end else begin
            state <= (state == IDLE && cpu_issue && !cpu_we) ? RD_WAIT : IDLE;

            if (upg_accept) begin
                buf_valid <= 1'b1;
                buf_addr  <= upg_addr;
                buf_wdata <= upg_wdata;
            end else if (buf_issue) begin
                buf_valid <= 1'b0;
            end

            if (buf_issue || !buf_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (upg_drop) begin
                upg_overflow <= 1'b1;
            end
        end
    end

    assign upg_busy = buf_valid;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cnt_cpu;
    logic [15:0] cnt_upg;
    logic [15:0] cnt_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_cpu   <= '0;
            cnt_upg   <= '0;
            cnt_stall <= '0;
        end else begin
            if (cpu_issue && cnt_cpu != 16'hFFFF) begin
                cnt_cpu <= cnt_cpu + 16'd1;
            end
            if (buf_issue && cnt_upg != 16'hFFFF) begin
                cnt_upg <= cnt_upg + 16'd1;
            end
            if (cpu_stall && cnt_stall != 16'hFFFF) begin
                cnt_stall <= cnt_stall + 16'd1;
            end
        end
    end

    assign stat_cpu   = cnt_cpu;
    assign stat_upg   = cnt_upg;
    assign stat_stall = cnt_stall;
`else
    assign stat_cpu   = '0;
    assign stat_upg   = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a queue-based reference model
module tb_dmem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SL = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req, cpu_we, upg_wen, upg_done;
    logic [AW-1:0] cpu_addr, upg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, upg_wdata, mem_wdata, cpu_rdata, mem_rdata;
    logic          cpu_stall, cpu_rvalid, upg_busy, upg_overflow, mem_we;
    logic [15:0]   stat_cpu, stat_upg, stat_stall;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .upg_wen(upg_wen), .upg_addr(upg_addr), .upg_wdata(upg_wdata), .upg_done(upg_done),
        .upg_busy(upg_busy), .upg_overflow(upg_overflow),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_cpu(stat_cpu), .stat_upg(stat_upg), .stat_stall(stat_stall)
    );

    // Bench-side synchronous memory, 1-cycle read latency, low 8 address bits decoded.
    logic          ram_clr;
    logic [DW-1:0] ram [0:255];
    always @(posedge clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    typedef struct {
        logic        stall, rvalid, busy, ovf, we;
        logic [15:0] s_cpu, s_upg, s_stall;
    } cyc_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    cyc_t          exp_q[$];
    wr_t           wr_q[$];
    logic [DW-1:0] rd_q[$];

    int errors, checks;
    bit mon_en;

    // Reference model: the UART buffer is a queue of depth one, the read pipeline a pending flag.
    logic [DW-1:0] shadow [0:255];
    wr_t           m_buf[$];
    int            m_wait, m_cpu, m_upg, m_stall;
    bit            m_rd_pend, m_ovf, m_last_stall;
    logic [DW-1:0] m_rd_data;

    logic          r_req, r_we;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_wait = 0; m_cpu = 0; m_upg = 0; m_stall = 0;
        m_rd_pend = 0; m_ovf = 0; m_last_stall = 0; m_rd_data = '0;
    endtask

    task automatic model_step();
        cyc_t e;
        wr_t  w;
        int   owner;
        bit   had;
        had      = (m_buf.size() != 0);
        e.rvalid = m_rd_pend;
        e.busy   = had;
        e.ovf    = m_ovf;
`ifdef DMEM_ARB_STATS_EN
        e.s_cpu = sat16(m_cpu); e.s_upg = sat16(m_upg); e.s_stall = sat16(m_stall);
`else
        e.s_cpu = '0; e.s_upg = '0; e.s_stall = '0;
`endif
        e.stall = 1'b0;
        owner   = 0;
        if (m_rd_pend) begin
            e.stall = cpu_req;
            if (had) owner = 2;
        end else if (had && m_wait >= SL) begin
            owner   = 2;
            e.stall = cpu_req;
        end else if (cpu_req) begin
            owner = 1;
        end else if (had) begin
            owner = 2;
        end
        if (m_rd_pend) rd_q.push_back(m_rd_data);
        m_rd_pend = 0;
        e.we = (owner == 2) || (owner == 1 && cpu_we);
        if (owner == 1) begin
            m_cpu++;
            if (cpu_we) begin
                w.addr = cpu_addr; w.data = cpu_wdata;
                wr_q.push_back(w);
                shadow[cpu_addr[7:0]] = cpu_wdata;
            end else begin
                m_rd_pend = 1;
                m_rd_data = shadow[cpu_addr[7:0]];
            end
        end else if (owner == 2) begin
            w = m_buf.pop_front();
            wr_q.push_back(w);
            shadow[w.addr[7:0]] = w.data;
            m_upg++;
        end
        if (e.stall) m_stall++;
        if (owner == 2 || !had) m_wait = 0;
        else m_wait++;
        if (upg_wen && !upg_done) begin
            if (m_buf.size() == 0) begin
                w.addr = upg_addr; w.data = upg_wdata;
                m_buf.push_back(w);
            end else begin
                m_ovf = 1;
            end
        end
        m_last_stall = e.stall;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic wen, input logic [AW-1:0] ua, input logic [DW-1:0] ud, input logic done);
        @(posedge clock);
        #1;
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        upg_wen = wen; upg_addr = ua; upg_wdata = ud; upg_done = done;
        model_step();
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Continuous CPU writes (held while stalled) with UART strobes at chosen cycles.
    task automatic cpu_writes(input int n, input int wen0, input int wen1);
        for (int i = 0; i < n; i++) begin
            if (!m_last_stall) begin
                r_req = 1'b1; r_we = 1'b1; r_a = 14'(64 + i); r_d = 32'hC0DE_0000 + 32'(i);
            end
            drive(r_req, r_we, r_a, r_d, (i == wen0) || (i == wen1), 14'(48 + i), 32'hA5A5_0000 + 32'(i), 1'b0);
        end
    endtask

    task automatic rand_cycles(input int n, input int req_pct, input int wen_pct);
        for (int i = 0; i < n; i++) begin
            if (!m_last_stall) begin
                r_req = ($urandom_range(99) < req_pct);
                r_we  = 1'($urandom_range(1));
                r_a   = 14'($urandom_range(63));
                r_d   = $urandom();
            end
            drive(r_req, r_we, r_a, r_d, ($urandom_range(99) < wen_pct),
                  14'($urandom_range(63)), $urandom(), ($urandom_range(99) < 8));
        end
    endtask

    always @(negedge clock) begin
        cyc_t          e;
        wr_t           w;
        logic [DW-1:0] r;
        if (mon_en && reset_n) begin
            chk("cycle_expectation_present", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cpu_stall", 64'(cpu_stall), 64'(e.stall));
                chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e.rvalid));
                chk("mem_we", 64'(mem_we), 64'(e.we));
                chk("upg_busy", 64'(upg_busy), 64'(e.busy));
                chk("upg_overflow", 64'(upg_overflow), 64'(e.ovf));
                chk("stat_cpu", 64'(stat_cpu), 64'(e.s_cpu));
                chk("stat_upg", 64'(stat_upg), 64'(e.s_upg));
                chk("stat_stall", 64'(stat_stall), 64'(e.s_stall));
            end
            if (mem_we) begin
                chk("write_expected", 64'(wr_q.size() != 0), 64'(1));
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(w.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(w.data));
                end
            end
            if (cpu_rvalid) begin
                chk("read_expected", 64'(rd_q.size() != 0), 64'(1));
                if (rd_q.size() != 0) begin
                    r = rd_q.pop_front();
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(r));
                end
            end
        end
    end

    initial begin
        errors = 0; checks = 0; mon_en = 0; ram_clr = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        model_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h011; cpu_wdata = 32'h1;
        upg_wen = 1'b0; upg_addr = '0; upg_wdata = '0; upg_done = 1'b0;
        r_req = 1'b0; r_we = 1'b0; r_a = '0; r_d = '0;
        repeat (2) @(posedge clock);
        #1;
        ram_clr = 1'b0;
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_cpu_stall", 64'(cpu_stall), 64'(0));
        chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        chk("rst_upg_busy", 64'(upg_busy), 64'(0));
        chk("rst_upg_overflow", 64'(upg_overflow), 64'(0));
        chk("rst_stat_cpu", 64'(stat_cpu), 64'(0));
        cpu_req = 1'b0; cpu_we = 1'b0;
        reset_n = 1'b1;

        drive(1'b1, 1'b1, 14'h010, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 14'h010, '0, 1'b0, '0, '0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h020, 32'h12345678, 1'b0);
        idle(2);
        cpu_writes(14, 0, -1);
        idle(2);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h021, 32'h0000_AAAA, 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h022, 32'h0000_BBBB, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 14'h021, '0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 14'h022, '0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 14'h022, '0, 1'b0, '0, '0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h023, 32'h0000_CCCC, 1'b1);
        idle(2);

        rand_cycles(2000, 60, 25);
        rand_cycles(1000, 97, 30);
        idle(3);

        cpu_writes(16, 0, 1);
        idle(3);

        drive(1'b1, 1'b0, 14'h005, '0, 1'b1, 14'h006, 32'hCAFEF00D, 1'b0);
        @(posedge clock);
        #1;
        mon_en = 0;
        cpu_req = 1'b0; upg_wen = 1'b0;
        chk("pre_rst_rvalid", 64'(cpu_rvalid), 64'(1));
        chk("pre_rst_busy", 64'(upg_busy), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(cpu_rvalid), 64'(0));
        chk("mid_rst_mem_we", 64'(mem_we), 64'(0));
        chk("mid_rst_upg_busy", 64'(upg_busy), 64'(0));
        chk("mid_rst_overflow", 64'(upg_overflow), 64'(0));
        chk("mid_rst_stat_cpu", 64'(stat_cpu), 64'(0));
        chk("mid_rst_stat_upg", 64'(stat_upg), 64'(0));
        chk("mid_rst_stat_stall", 64'(stat_stall), 64'(0));
        @(posedge clock);
        #1 reset_n = 1'b1;
        exp_q.delete(); wr_q.delete(); rd_q.delete();
        model_reset();
        idle(4);
        rand_cycles(300, 70, 30);
        idle(4);
        @(negedge clock);
        #1;
        chk("writes_drained", 64'(wr_q.size()), 64'(0));
        chk("reads_drained", 64'(rd_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
